apb2_master_arb: RTL

Shares one APB2 master port (pselx/penable/pwrite/paddr/pwdata/prdata) between NUM_REQ on-chip requesters. Sits between requester-side agents (sequencer bridges, register-programming engines) and the APB2 master interface. Runs round-robin arbitration, sequences each transfer through the APB2 SETUP and ACCESS phases, and returns read data to the winning requester. APB2 has no pready/pslverr, so every transfer is exactly two bus cycles.

---
 rtl/apb2_master_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/apb2_master_arb.sv
// Round-robin arbiter sharing one APB2 master port between NUM_REQ requesters.
// Every transfer is SETUP then ACCESS; read data returns one cycle after ACCESS.
module apb2_master_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             busy,
  output logic                             pselx,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [DATA_WIDTH-1:0]            prdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [IDX_W-1:0]      owner_reg;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W:0]        cand;
  logic                  grant_found;
  logic                  can_grant;
  logic                  handshake;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from the highest offset down so the candidate closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grants are only offered when the bus can start a new SETUP next cycle.
  assign can_grant = ((state_reg == IDLE) || (state_reg == ACCESS)) && !preset;
  assign handshake = can_grant && grant_found;
  assign req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = handshake ? SETUP : IDLE;
      SETUP:   state_next = ACCESS;
      ACCESS:  state_next = handshake ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        paddr     <= addr_arr[grant_idx];
        pwdata    <= wdata_arr[grant_idx];
        pwrite    <= req_write[grant_idx];
        owner_reg <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      rsp_valid <= '0;
      if (state_reg == ACCESS) begin
        rsp_valid <= NUM_REQ'(1) << owner_reg;
        rsp_rdata <= pwrite ? '0 : prdata;
      end
    end
  end

  assign pselx   = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable = (state_reg == ACCESS);
  assign busy    = pselx;

endmodule
